// File: rtl/gpi_debounce.sv
// Switch input conditioning: per-bit 2-flop synchroniser plus stability
// counter, producing clean levels, rise/fall pulses and an any-change pulse.

// One input bit: synchroniser, stability counter, debounced state and pulses.
module gpi_debounce_bit #(
  parameter int   DebounceCycles = 50000,
  parameter int   CntWidth       = 16,
  parameter logic ResetBit       = 1'b0
) (
  input  logic clk_sys_i,
  input  logic rst_sys_ni,
  input  logic raw_i,
  output logic deb_o,
  output logic rise_o,
  output logic fall_o,
  output logic accept_o
);
  localparam logic [CntWidth-1:0] Last = CntWidth'(DebounceCycles - 1);

  logic                sync1, sync2;
  logic [CntWidth-1:0] cnt;
  logic                differ;

  // Counter only ever sees a differing level; it stops at Last so it never wraps.
  assign differ   = (sync2 != deb_o);
  assign accept_o = differ && (cnt == Last);

  // Synchronise, count consecutive differing cycles, accept at the limit.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      sync1  <= ResetBit;
      sync2  <= ResetBit;
      deb_o  <= ResetBit;
      cnt    <= '0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      sync1  <= raw_i;
      sync2  <= sync1;
      rise_o <= accept_o &&  sync2;
      fall_o <= accept_o && !sync2;
      if (!differ || accept_o) cnt <= '0;
      else                     cnt <= cnt + 1'b1;
      if (accept_o) deb_o <= sync2;
    end
  end
endmodule

module gpi_debounce #(
  parameter int               Width          = 13,
  parameter int               DebounceCycles = 50000,
  parameter int               CntWidth       = 16,
  parameter logic [Width-1:0] ResetValue     = '0
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  input  logic [Width-1:0] raw_i,
  output logic [Width-1:0] deb_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic             changed_o
);
  logic [Width-1:0] accept;

  // Bits are fully independent; one debouncer lane per input.
  for (genvar i = 0; i < Width; i++) begin : g_lane
    gpi_debounce_bit #(
      .DebounceCycles(DebounceCycles),
      .CntWidth      (CntWidth),
      .ResetBit      (ResetValue[i])
    ) u_bit (
      .clk_sys_i (clk_sys_i),
      .rst_sys_ni(rst_sys_ni),
      .raw_i     (raw_i[i]),
      .deb_o     (deb_o[i]),
      .rise_o    (rise_o[i]),
      .fall_o    (fall_o[i]),
      .accept_o  (accept[i])
    );
  end

  // Registered alongside rise/fall so all pulses share the deb_o update edge.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) changed_o <= 1'b0;
    else             changed_o <= |accept;
  end
endmodule

// File: tb/tb_gpi_debounce.sv
// Directed bench for gpi_debounce (Width=4, DebounceCycles=4) with a
// window-based reference model compared every cycle plus literal checks.
module tb_gpi_debounce;
  localparam int         W  = 4;
  localparam int         D  = 4;
  localparam logic [W-1:0] RV = '0;

  logic         clk_sys_i  = 1'b0;
  logic         rst_sys_ni = 1'b0;
  logic [W-1:0] raw_i      = '0;
  logic [W-1:0] deb_o, rise_o, fall_o;
  logic         changed_o;

  int n_checks = 0;
  int n_errors = 0;

  gpi_debounce #(
    .Width(W), .DebounceCycles(D), .CntWidth(16), .ResetValue(RV)
  ) dut (
    .clk_sys_i (clk_sys_i),
    .rst_sys_ni(rst_sys_ni),
    .raw_i     (raw_i),
    .deb_o     (deb_o),
    .rise_o    (rise_o),
    .fall_o    (fall_o),
    .changed_o (changed_o)
  );

  always #10 clk_sys_i = ~clk_sys_i;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the debouncer sees raw_i as sampled two edges earlier.
  // A bit is accepted when its last D seen samples all agree, differ from
  // the current level, and all postdate the previous acceptance.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_deb, m_rise, m_fall;
  logic         m_chg;
  int           since[W];

  initial begin
    hist = '{RV, RV};
    m_deb = RV; m_rise = '0; m_fall = '0; m_chg = 1'b0;
    for (int i = 0; i < W; i++) since[i] = 0;
    forever begin
      @(posedge clk_sys_i or negedge rst_sys_ni);
      if (!rst_sys_ni) begin
        hist = '{RV, RV};
        m_deb = RV; m_rise = '0; m_fall = '0; m_chg = 1'b0;
        for (int i = 0; i < W; i++) since[i] = 0;
      end else begin
        hist.push_back(raw_i);
        if (hist.size() > 16) void'(hist.pop_front());
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < W; i++) begin
          since[i]++;
          if (since[i] >= D && hist.size() >= D + 2) begin
            logic [W-1:0] e;
            logic         v, same;
            e    = hist[hist.size() - 3];
            v    = e[i];
            same = 1'b1;
            for (int j = 0; j < D; j++) begin
              e = hist[hist.size() - 3 - j];
              if (e[i] != v) same = 1'b0;
            end
            if (same && v != m_deb[i]) begin
              m_deb[i] = v;
              if (v) m_rise[i] = 1'b1;
              else   m_fall[i] = 1'b1;
              since[i] = 0;
            end
          end
        end
        m_chg = |(m_rise | m_fall);
      end
    end
  end

  // Compare DUT against the model every cycle outside reset.
  initial begin
    forever begin
      @(negedge clk_sys_i);
      #2;
      if (rst_sys_ni) begin
        check("model_deb",  deb_o,  m_deb);
        check("model_rise", rise_o, m_rise);
        check("model_fall", fall_o, m_fall);
        check("model_chg",  {3'b0, changed_o}, {3'b0, m_chg});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_sys_i);
  endtask

  logic pat[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    // 1: reset with raw=1010, no pulse at release, accepted at edge 6
    raw_i = 4'b1010;
    step(3);
    check("rst_deb",  deb_o,  4'b0000);
    check("rst_rise", rise_o, 4'b0000);
    check("rst_fall", fall_o, 4'b0000);
    check("rst_chg",  {3'b0, changed_o}, 4'b0000);
    rst_sys_ni = 1'b1;
    step(5);
    check("t1_deb_e5",  deb_o,  4'b0000);
    check("t1_rise_e5", rise_o, 4'b0000);
    step(1);
    check("t1_deb_e6",  deb_o,  4'b1010);
    check("t1_rise_e6", rise_o, 4'b1010);
    check("t1_chg_e6",  {3'b0, changed_o}, 4'b0001);
    step(1);
    check("t1_rise_e7", rise_o, 4'b0000);
    check("t1_chg_e7",  {3'b0, changed_o}, 4'b0000);

    // 2: clean rise latency on bit 0
    raw_i = 4'b1011;
    step(5);
    check("t2_deb_e5",  deb_o,  4'b1010);
    step(1);
    check("t2_deb_e6",  deb_o,  4'b1011);
    check("t2_rise_e6", rise_o, 4'b0001);
    step(1);
    check("t2_rise_e7", rise_o, 4'b0000);

    raw_i = 4'b0000;
    step(10);
    check("clear_deb", deb_o, 4'b0000);

    // 3: 3-cycle glitch rejected, then a held level accepted
    raw_i = 4'b0010;
    step(3);
    raw_i = 4'b0000;
    step(10);
    check("t3_glitch_deb", deb_o, 4'b0000);
    raw_i = 4'b0010;
    step(5);
    check("t3_deb_e5", deb_o, 4'b0000);
    step(1);
    check("t3_deb_e6",  deb_o,  4'b0010);
    check("t3_rise_e6", rise_o, 4'b0010);

    // 4: bounce restarts the count; acceptance 6 edges after the re-entry
    for (int k = 0; k < 8; k++) begin
      raw_i[2] = pat[k];
      step(1);
    end
    step(1);
    check("t4_deb_early", deb_o, 4'b0010);
    step(1);
    check("t4_deb",  deb_o,  4'b0110);
    check("t4_rise", rise_o, 4'b0100);

    // 5: simultaneous fall on bit 0 and rise on bit 3
    raw_i = 4'b0111;
    step(8);
    check("t5_setup", deb_o, 4'b0111);
    raw_i = 4'b1110;
    step(5);
    check("t5_fall_e5", fall_o, 4'b0000);
    step(1);
    check("t5_fall", fall_o, 4'b0001);
    check("t5_rise", rise_o, 4'b1000);
    check("t5_chg",  {3'b0, changed_o}, 4'b0001);
    check("t5_deb",  deb_o,  4'b1110);
    step(1);
    check("t5_chg_e7", {3'b0, changed_o}, 4'b0000);

    // 6: reset mid-count discards the partial count
    raw_i = 4'b1111;
    step(4);
    rst_sys_ni = 1'b0;
    #1;
    check("t6_async_deb", deb_o, 4'b0000);
    step(2);
    rst_sys_ni = 1'b1;
    step(5);
    check("t6_deb_e5",  deb_o,  4'b0000);
    check("t6_rise_e5", rise_o, 4'b0000);
    step(1);
    check("t6_deb_e6",  deb_o,  4'b1111);
    check("t6_rise_e6", rise_o, 4'b1111);
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
